mc_request_queue: RTL and testbench

//  Memory-controller input request queue, directly downstream of the trace-file parser.
//  - Admits each parsed request <time, op, addr> only once the simulated CPU cycle reaches its

---
 rtl/mc_request_queue.sv | 107 ++++++++++
 tb/tb_mc_request_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_request_queue.sv
// rtl/mc_request_queue.sv - timestamp-gated memory request FIFO with global cycle counter
// Optional feature macro: MCQ_TIME_SKIP_EN (jump cur_cycle to the next request time when idle)
module mc_request_queue #(
    parameter int ADDR_WIDTH  = 36,
    parameter int MEMOP_WIDTH = 2,
    parameter int TIME_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 16,
    localparam int PTR_W      = $clog2(QUEUE_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [TIME_WIDTH-1:0]  in_time,
    input  logic [MEMOP_WIDTH-1:0] in_op,
    input  logic [ADDR_WIDTH-1:0]  in_addr,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [MEMOP_WIDTH-1:0] out_op,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [TIME_WIDTH-1:0]  out_wait,
    input  logic                   out_ready,
    output logic [PTR_W:0]         count,
    output logic                   full,
    output logic                   empty,
    output logic [TIME_WIDTH-1:0]  cur_cycle,
    output logic                   err_illegal_op,
    output logic                   err_time_order
);

    localparam logic [MEMOP_WIDTH-1:0] OP_ILLEGAL = MEMOP_WIDTH'(3);
    localparam logic [PTR_W:0]         DEPTH_CNT  = (PTR_W+1)'(QUEUE_DEPTH);

    logic [MEMOP_WIDTH-1:0] op_mem   [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  addr_mem [QUEUE_DEPTH];
    logic [TIME_WIDTH-1:0]  enq_mem  [QUEUE_DEPTH];

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [TIME_WIDTH-1:0] last_time;
    logic [TIME_WIDTH-1:0] next_cycle;
    logic                  is_illegal;
    logic                  arrived;
    logic                  push;
    logic                  drop;
    logic                  pop;

    assign is_illegal = (in_op == OP_ILLEGAL);
    assign arrived    = (in_time <= cur_cycle);
    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);

    // Illegal ops are always swallowed, even when full, so the parser never stalls on them.
    assign in_ready   = in_valid && arrived && (!full || is_illegal);
    assign push       = in_ready && !is_illegal;
    assign drop       = in_ready && is_illegal;
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;

    assign out_op   = empty ? '0 : op_mem[head];
    assign out_addr = empty ? '0 : addr_mem[head];
    assign out_wait = empty ? '0 : (cur_cycle - enq_mem[head]);

`ifdef MCQ_TIME_SKIP_EN
    always_comb begin
        next_cycle = cur_cycle + TIME_WIDTH'(1);
        if (empty && in_valid && (in_time > cur_cycle))
            next_cycle = in_time;
    end
`else
    assign next_cycle = cur_cycle + TIME_WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[tail]   <= in_op;
            addr_mem[tail] <= in_addr;
            enq_mem[tail]  <= cur_cycle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            cur_cycle      <= '0;
            last_time      <= '0;
            err_illegal_op <= 1'b0;
            err_time_order <= 1'b0;
        end else begin
            cur_cycle      <= next_cycle;
            err_illegal_op <= drop;
            err_time_order <= push && (in_time < last_time);
            if (push) begin
                tail      <= tail + PTR_W'(1);
                last_time <= in_time;
            end
            if (pop)
                head <= head + PTR_W'(1);
            if (push && !pop)
                count <= count + (PTR_W+1)'(1);
            else if (pop && !push)
                count <= count - (PTR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_mc_request_queue.sv
// tb/tb_mc_request_queue.sv - directed self-checking bench for mc_request_queue
module tb_mc_request_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_time = '0;
    logic [1:0]  in_op = '0;
    logic [35:0] in_addr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [1:0]  out_op;
    logic [35:0] out_addr;
    logic [31:0] out_wait;
    logic        out_ready = 1'b0;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [31:0] cur_cycle;
    logic        err_illegal_op;
    logic        err_time_order;

    int pass_cnt = 0;
    int total_cnt = 0;

    mc_request_queue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_time(in_time), .in_op(in_op), .in_addr(in_addr),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_op(out_op), .out_addr(out_addr), .out_wait(out_wait),
        .out_ready(out_ready),
        .count(count), .full(full), .empty(empty), .cur_cycle(cur_cycle),
        .err_illegal_op(err_illegal_op), .err_time_order(err_time_order)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge; each step advances exactly one posedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL reset_flags: count=%0d empty=%0b full=%0b out_valid=%0b required 0/1/0/0",
                     count, empty, full, out_valid);
        else pass_cnt++;
        total_cnt++;
        if (cur_cycle !== 32'd0 || err_illegal_op !== 1'b0 || err_time_order !== 1'b0 || out_addr !== 36'd0)
            $display("FAIL reset_regs: cur_cycle=%0d errs=%0b%0b out_addr=%0h required 0", cur_cycle,
                     err_illegal_op, err_time_order, out_addr);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (cur_cycle !== 32'd1) $display("FAIL reset_first_cycle: got %0d required 1", cur_cycle);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_time = 0; in_op = 0; in_addr = 36'h50 + 36'(i);
            step();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 5'd7) $display("FAIL midfill_count: got %0d required 7", count);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (count !== 5'd0 || empty !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL async_reset: count=%0d empty=%0b out_valid=%0b required 0/1/0", count, empty, out_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (cur_cycle !== 32'd0) $display("FAIL reset_hold_cycle: got %0d required 0", cur_cycle);
        else pass_cnt++;
        rst = 1'b0;
        in_valid = 1'b1; in_time = 0; in_op = 2'd1; in_addr = 36'h77;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 5'd1 || out_addr !== 36'h77 || out_op !== 2'd1)
            $display("FAIL push_after_reset: count=%0d addr=%0h op=%0d required 1/77/1", count, out_addr, out_op);
        else pass_cnt++;
    endtask

    task automatic test_full();
        logic ok;
        do_reset();
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_time = 0; in_op = 0; in_addr = 36'hA0 + 36'(i);
            #1;
            if (in_ready !== 1'b1) ok = 1'b0;
            step();
        end
        total_cnt++;
        if (!ok) $display("FAIL fill_ready: in_ready dropped before queue full (required 1)");
        else pass_cnt++;
        in_addr = 36'hB0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0 || full !== 1'b1 || count !== 5'd16)
            $display("FAIL full_block: in_ready=%0b full=%0b count=%0d required 0/1/16", in_ready, full, count);
        else pass_cnt++;
        total_cnt++;
        if (out_addr !== 36'hA0) $display("FAIL full_head: got %0h required a0", out_addr);
        else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL full_pop_no_path: in_ready=%0b required 0", in_ready);
        else pass_cnt++;
        step();
        out_ready = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || count !== 5'd15 || full !== 1'b0)
            $display("FAIL after_pop: in_ready=%0b count=%0d full=%0b required 1/15/0", in_ready, count, full);
        else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 5'd16) $display("FAIL refill_count: got %0d required 16", count);
        else pass_cnt++;
        ok = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            if (out_valid !== 1'b1 || out_addr !== 36'hA1 + 36'(j)) begin
                ok = 1'b0;
                $display("FAIL drain_order_%0d: addr=%0h valid=%0b required %0h/1", j, out_addr, out_valid, 36'hA1 + 36'(j));
            end
            step();
        end
        out_ready = 1'b0;
        total_cnt++;
        if (!ok || count !== 5'd0 || empty !== 1'b1 || out_addr !== 36'd0)
            $display("FAIL drain_end: count=%0d empty=%0b addr=%0h required 0/1/0", count, empty, out_addr);
        else pass_cnt++;
    endtask

    task automatic test_arrival();
        logic ok;
        do_reset();
        steps(3);
        total_cnt++;
        if (cur_cycle !== 32'd3) $display("FAIL arrive_start: cur_cycle=%0d required 3", cur_cycle);
        else pass_cnt++;
        in_valid = 1'b1; in_time = 10; in_op = 2'd1; in_addr = 36'h123;
        ok = 1'b1;
`ifdef MCQ_TIME_SKIP_EN
        #1;
        if (in_ready !== 1'b0) ok = 1'b0;
        step();
`else
        for (int c = 3; c < 10; c++) begin
            #1;
            if (in_ready !== 1'b0) ok = 1'b0;
            step();
        end
`endif
        total_cnt++;
        if (!ok) $display("FAIL arrive_early: in_ready rose before cycle 10 (required 0)");
        else pass_cnt++;
        #1;
        total_cnt++;
        if (cur_cycle !== 32'd10 || in_ready !== 1'b1)
            $display("FAIL arrive_admit: cur_cycle=%0d in_ready=%0b required 10/1", cur_cycle, in_ready);
        else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (count !== 5'd1 || out_addr !== 36'h123 || out_wait !== 32'd1)
            $display("FAIL arrive_stored: count=%0d addr=%0h wait=%0d required 1/123/1", count, out_addr, out_wait);
        else pass_cnt++;
    endtask

    task automatic test_illegal_op();
        in_valid = 1'b1; in_time = 0; in_op = 2'd3; in_addr = 36'h1FF97000;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL illegal_ready: got %0b required 1", in_ready);
        else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (err_illegal_op !== 1'b1 || count !== 5'd1 || err_time_order !== 1'b0)
            $display("FAIL illegal_pulse: err=%0b count=%0d order=%0b required 1/1/0", err_illegal_op, count, err_time_order);
        else pass_cnt++;
        step();
        total_cnt++;
        if (err_illegal_op !== 1'b0 || out_addr !== 36'h123)
            $display("FAIL illegal_clear: err=%0b addr=%0h required 0/123", err_illegal_op, out_addr);
        else pass_cnt++;
    endtask

    task automatic test_time_order();
        do_reset();
        steps(20);
        in_valid = 1'b1; in_time = 20; in_op = 0; in_addr = 36'h111;
        step();
        total_cnt++;
        if (err_time_order !== 1'b0) $display("FAIL order_first: err=%0b required 0", err_time_order);
        else pass_cnt++;
        in_time = 15; in_addr = 36'h222;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (err_time_order !== 1'b1 || count !== 5'd2 || out_addr !== 36'h111)
            $display("FAIL order_pulse: err=%0b count=%0d addr=%0h required 1/2/111", err_time_order, count, out_addr);
        else pass_cnt++;
        step();
        total_cnt++;
        if (err_time_order !== 1'b0) $display("FAIL order_clear: err=%0b required 0", err_time_order);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic ok;
        do_reset();
        steps(40);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_time = 40; in_op = 2'd2; in_addr = 36'h300 + 36'(i);
            step();
        end
        in_valid = 1'b0;
        steps(2);
        total_cnt++;
        if (cur_cycle !== 32'd47 || out_wait !== 32'd7 || out_addr !== 36'h300 || out_op !== 2'd2)
            $display("FAIL wait_head: cycle=%0d wait=%0d addr=%0h op=%0d required 47/7/300/2", cur_cycle, out_wait, out_addr, out_op);
        else pass_cnt++;
        in_valid = 1'b1; in_addr = 36'h305; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        total_cnt++;
        if (count !== 5'd5 || out_addr !== 36'h301 || out_wait !== 32'd7)
            $display("FAIL push_pop: count=%0d addr=%0h wait=%0d required 5/301/7", count, out_addr, out_wait);
        else pass_cnt++;
        ok = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (out_addr !== 36'h301 + 36'(j)) ok = 1'b0;
            step();
        end
        out_ready = 1'b0;
        total_cnt++;
        if (!ok || empty !== 1'b1 || out_valid !== 1'b0 || out_wait !== 32'd0 || out_op !== 2'd0)
            $display("FAIL b2b_drain: order_ok=%0b empty=%0b valid=%0b wait=%0d op=%0d required 1/1/0/0/0",
                     ok, empty, out_valid, out_wait, out_op);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_fill();
        test_full();
        test_arrival();
        test_illegal_op();
        test_time_order();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
